// File: rtl/prco_fetch_unit.sv
// prco_fetch_unit: pipelined instruction fetch front end for the prco core.
// It generates PCs, issues reads with several requests in flight, buffers the
// returned words in an in-order instruction queue and handles branch redirects.
// A redirect squashes both the queue contents and any reads still in flight.
// Optional build macro PRCO_FETCH_DEBUG_EN adds a pop pulse and a pop counter.
module prco_fetch_unit #(
   parameter int ADDR_W      = 16,
   parameter int INSTR_W     = 16,
   parameter int QUEUE_DEPTH = 4,
   parameter int PC_RESET    = 0,
   parameter int PC_LIMIT    = 0
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_en,
   output logic               q_mem_req,
   output logic [ADDR_W-1:0]  q_mem_addr,
   input  logic               i_mem_ack,
   input  logic               i_mem_valid,
   input  logic [INSTR_W-1:0] i_mem_data,
   output logic               q_instr_valid,
   output logic [INSTR_W-1:0] q_instr,
   output logic [ADDR_W-1:0]  q_instr_pc,
   input  logic               i_instr_ready,
   input  logic               i_branch,
   input  logic [ADDR_W-1:0]  i_branch_target
`ifdef PRCO_FETCH_DEBUG_EN
   ,
   output logic               q_debug_instr_clk,
   output logic [31:0]        q_fetch_count
`endif
);

   localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
   localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(PC_RESET);
   localparam logic [ADDR_W-1:0] LIMIT_ADDR = ADDR_W'(PC_LIMIT);
   localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(QUEUE_DEPTH);

   // Address sequencing: wrap to the reset PC after the limit, else increment
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      if (PC_LIMIT != 0 && a >= LIMIT_ADDR)
         next_addr = RESET_ADDR;
      else
         next_addr = a + ADDR_W'(1);
   endfunction

   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  resp_pc;
   logic [CNT_W-1:0]   outstanding;
   logic [CNT_W-1:0]   drop;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   outstanding_nxt;
   logic [CNT_W-1:0]   drop_base;
   logic [CNT_W-1:0]   drop_nxt;
   logic [CNT_W:0]     in_flight;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [INSTR_W-1:0] q_data [QUEUE_DEPTH];
   logic [ADDR_W-1:0]  q_pc   [QUEUE_DEPTH];
   logic               issue;
   logic               push;
   logic               pop;
   logic               full;

   // The issue cap counts queued words plus reads in flight, so every
   // response always has a queue slot waiting for it.
   assign in_flight     = {1'b0, count} + {1'b0, outstanding};
   assign q_mem_req     = i_en & ~i_reset & (in_flight < {1'b0, DEPTH_CNT});
   assign q_mem_addr    = pc;
   assign issue         = q_mem_req & i_mem_ack;
   assign q_instr_valid = (count != '0);
   assign full          = (count == DEPTH_CNT);
   assign pop           = q_instr_valid & i_instr_ready & ~i_branch;
   assign push          = i_mem_valid & (drop == '0) & ~i_branch;
   assign q_instr       = q_instr_valid ? q_data[rd_ptr] : '0;
   assign q_instr_pc    = q_instr_valid ? q_pc[rd_ptr]   : '0;

   // In-flight and squash bookkeeping; a redirect marks every read still in
   // flight after this cycle's ack and response as stale.
   always_comb begin
      outstanding_nxt = outstanding + CNT_W'(issue) - CNT_W'(i_mem_valid);
      drop_base       = drop;
      if (i_mem_valid && drop != '0)
         drop_base = drop - CNT_W'(1);
      drop_nxt = drop_base;
      if (i_branch)
         drop_nxt = drop_base + outstanding_nxt;
   end

   // Fetch PC, expected response PC and in-flight counters
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         pc          <= RESET_ADDR;
         resp_pc     <= RESET_ADDR;
         outstanding <= '0;
         drop        <= '0;
      end else begin
         outstanding <= outstanding_nxt;
         drop        <= drop_nxt;
         if (i_branch) begin
            pc      <= i_branch_target;
            resp_pc <= i_branch_target;
         end else begin
            if (issue)
               pc <= next_addr(pc);
            if (push)
               resp_pc <= next_addr(resp_pc);
         end
      end
   end

   // Queue pointers and occupancy; a redirect empties the queue outright
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (i_branch) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         count <= count + CNT_W'(push) - CNT_W'(pop);
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // Queue storage: each entry holds the word and the address it came from
   always_ff @(posedge i_clk) begin
      if (push) begin
         q_data[wr_ptr] <= i_mem_data;
         q_pc[wr_ptr]   <= resp_pc;
      end
   end

   // Pushing into a full queue without a pop means the issue cap was broken
   a_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
                                   !(push && full && !pop));

`ifdef PRCO_FETCH_DEBUG_EN
   // Debug pop pulse and free-running count of instructions handed over
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         q_debug_instr_clk <= 1'b0;
         q_fetch_count     <= '0;
      end else begin
         q_debug_instr_clk <= pop;
         if (pop)
            q_fetch_count <= q_fetch_count + 32'd1;
      end
   end
`else
   // Debug build disabled: no pop pulse or pop counter is present
`endif

endmodule

// File: doc/prco_fetch_unit.md
Name: prco_fetch_unit

Overview:
Parametrised instruction fetch unit for the prco core. It replaces the fixed single-outstanding PC/fetch logic with a pipelined front end: a PC generator, a memory request/response handshake with multiple outstanding reads, an instruction queue feeding the decoder, and branch redirect with flush of in-flight fetches. It sits between the local instruction memory (prco_lmem or successor) and prco_decoder.

Parameters:
ADDR_W, 16, PC and memory address width
INSTR_W, 16, instruction word width
QUEUE_DEPTH, 4, instruction queue entries; also the cap on queued plus outstanding fetches (power of 2, 2..16)
PC_RESET, 0, PC value after reset and on limit wrap
PC_LIMIT, 0, last fetched address before wrapping to PC_RESET; 0 = natural 2^ADDR_W wrap

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_en  in  1  fetch enable; low = issue no new requests
q_mem_req  out  1  read request valid
q_mem_addr  out  ADDR_W  read address
i_mem_ack  in  1  memory accepts request this cycle
i_mem_valid  in  1  read data valid (in order, >=1 cycle after ack)
i_mem_data  in  INSTR_W  read data
q_instr_valid  out  1  queue head valid
q_instr  out  INSTR_W  queue head instruction
q_instr_pc  out  ADDR_W  address of queue head
i_instr_ready  in  1  decoder pops head when valid & ready
i_branch  in  1  single-cycle redirect strobe
i_branch_target  in  ADDR_W  redirect address

Behaviour:
- Reset (async, i_reset high): pc=PC_RESET, resp_pc=PC_RESET, queue empty, outstanding=0, drop=0; q_mem_req=0, q_mem_addr=PC_RESET, q_instr_valid=0, q_instr=0, q_instr_pc=0. Reset mid-operation discards everything; the memory must share the same reset.
- Next-address rule next(a): if PC_LIMIT!=0 and a>=PC_LIMIT then PC_RESET, else a+1 modulo 2^ADDR_W.
- Issue: q_mem_req = i_en & (count + outstanding < QUEUE_DEPTH), count = queue occupancy. q_mem_addr = pc. No combinational path from any memory input to q_mem_req/q_mem_addr. On req & ack: pc<=next(pc), outstanding+1.
- Response: on i_mem_valid, outstanding-1. If drop>0: discard, drop-1. Otherwise push {i_mem_data, resp_pc}, resp_pc<=next(resp_pc). Queue never overflows due to the issue cap; a push into a full queue is a design error (assert in simulation).
- Output: registered FIFO; head visible the cycle after the push edge (1-cycle response-to-valid latency). Pop on valid & ready; simultaneous push and pop is legal at any occupancy including full.
- Branch (i_branch high at an edge, regardless of i_en): queue cleared; pc<=target; resp_pc<=target; drop<=drop + outstanding, where outstanding is first updated for this cycle's ack(+1) and response(-1). A response arriving in the branch cycle is discarded. A pop in the branch cycle has no effect. q_instr_valid is 0 in the following cycle. Back-to-back branches: the last one wins; drop accumulates correctly.
- i_en low: no issue; responses still accepted; queue still drains.
- Counters outstanding and drop are sized for QUEUE_DEPTH; drop never exceeds QUEUE_DEPTH.

Optional Feature:
PRCO_FETCH_DEBUG_EN: when defined, adds output q_debug_instr_clk (1-cycle pulse per popped instruction, reset 0) and output q_fetch_count [31:0] (count of popped instructions, reset 0, wraps at 2^32, not cleared by branch). When undefined, neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset, i_en=1, ack always 1, 1-cycle memory latency, ready=1, PC_LIMIT=0 -> addresses 0,1,2,3... one per cycle; instructions delivered in order with q_instr_pc 0,1,2,3.
- ready=0, QUEUE_DEPTH=4 -> exactly 4 requests (addr 0..3) then q_mem_req=0; raise ready -> pops 0..3 and issue resumes at addr 4.
- 3-cycle latency, 3 outstanding, i_branch with target 0x0040 -> the 3 old responses are discarded; first delivered q_instr_pc=0x0040, then 0x0041.
- PC_LIMIT=6, PC_RESET=0 -> request addresses 0,1,2,3,4,5,6,0,1; q_instr_pc follows the same sequence.
- Branch in the same cycle as ack and i_mem_valid with outstanding=2 -> drop=2, both stale responses discarded, next fetch at the target.
- Assert i_reset mid-stream with queue holding 3 entries -> q_instr_valid=0 and q_mem_req=0 immediately; after release, fetch restarts at PC_RESET.
